// File: rtl/tb_monitor_pkg.sv
// ---------------------------------------------------------------------------
// tb_monitor_pkg
//   Shared types and constants for the DUT output monitor.
//   - monitor_rec_t : one captured record {data, timestamp} at default widths
//   - DROP_CNT_W    : width of the saturating dropped-capture counter
//   - sat_inc_drop  : saturating increment for the drop counter
// ---------------------------------------------------------------------------
package tb_monitor_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TS_WIDTH   = 32;
  localparam int DROP_CNT_W     = 16;

  // The timestamp field is called "ts" because "time" is a reserved word.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_TS_WIDTH-1:0]   ts;
  } monitor_rec_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Single-clock FIFO with a registered first-word-fall-through head.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push_i        write din_i (ignored when full unless popping same edge)
//     pop_i         remove head (ignored when empty)
//     din_i         write data
//     dout_o        registered head entry (holds last value while empty)
//     empty_o       registered: no entry at the head
//     full_o        count_o == DEPTH
//     push_ok_o     push accepted this cycle
//     count_o       entries stored (including the head)
// ---------------------------------------------------------------------------
module tb_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     push_ok_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;

  logic full;
  logic pop_ok;
  logic push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & valid_q;
  // When full, a push only fits if the head leaves on the same edge.
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = valid_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);

    // Preload the head register with whatever sits at the new read pointer.
    // If that slot is being written this very edge, the array does not hold
    // it yet, so take the incoming word directly.
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = din_i;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign dout_o    = head_q;
  assign empty_o   = ~valid_q;
  assign full_o    = full;
  assign push_ok_o = push_ok;
  assign count_o   = count_q;

endmodule

// File: rtl/dut_output_monitor.sv
// ---------------------------------------------------------------------------
// dut_output_monitor
//   Passive monitor: samples dut_outputs each enabled hub clock, timestamps the
//   capture with the hub cycle count, buffers records in a FIFO and hands them
//   out over valid/ready. Dropped captures are flagged and counted.
//   Ports:
//     hub_clocks      clock, all logic on posedge
//     hub_reset       asynchronous active-high reset
//     enable          capture / count enable
//     dut_outputs     sampled DUT outputs
//     rec_valid       record available at head
//     rec_ready       consumer accepts head when rec_valid & rec_ready
//     rec_data        captured value at head
//     rec_time        cycle count at capture of head
//     rec_count       entries currently stored
//     overflow        sticky: a capture was dropped
//     drop_count      dropped captures, saturating
//     clear_overflow  clears overflow and drop_count (a same-edge drop wins)
// ---------------------------------------------------------------------------
module dut_output_monitor
  import tb_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 32,
  parameter bit ON_CHANGE  = 1'b1
) (
  input  logic                    hub_clocks,
  input  logic                    hub_reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   dut_outputs,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [DATA_WIDTH-1:0]   rec_data,
  output logic [TS_WIDTH-1:0]     rec_time,
  output logic [$clog2(DEPTH):0]  rec_count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count,
  input  logic                    clear_overflow
);

  localparam int RW = DATA_WIDTH + TS_WIDTH;

  logic [TS_WIDTH-1:0]   cycle_q, cycle_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  first_pending_q, first_pending_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic          capture;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push_ok;
  logic [RW-1:0] fifo_din;
  logic [RW-1:0] fifo_dout;

  // first_pending forces a capture after reset or after a pause in enable,
  // even if the value matches the last one seen.
  assign capture = enable & ((ON_CHANGE == 1'b0) | first_pending_q | (dut_outputs != last_q));
  assign pop     = ~fifo_empty & rec_ready;
  assign drop    = capture & fifo_full & ~pop;

  // Timestamp is the counter value before this edge's increment.
  assign fifo_din = {dut_outputs, cycle_q};

  always_comb begin
    cycle_d         = cycle_q;
    last_d          = last_q;
    first_pending_d = first_pending_q;
    overflow_d      = overflow_q;
    drop_d          = drop_q;

    if (enable) begin
      cycle_d = cycle_q + TS_WIDTH'(1);
    end

    // Even a dropped capture becomes the new reference for change detection.
    if (capture) begin
      last_d          = dut_outputs;
      first_pending_d = 1'b0;
    end
    if (!enable) begin
      first_pending_d = 1'b1;
    end

    // A drop on the same edge as a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      drop_d     = clear_overflow ? DROP_CNT_W'(1) : sat_inc_drop(drop_q);
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset) begin
      cycle_q         <= '0;
      last_q          <= '0;
      first_pending_q <= 1'b1;
      overflow_q      <= 1'b0;
      drop_q          <= '0;
    end else begin
      cycle_q         <= cycle_d;
      last_q          <= last_d;
      first_pending_q <= first_pending_d;
      overflow_q      <= overflow_d;
      drop_q          <= drop_d;
    end
  end

  tb_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (hub_clocks),
    .rst       (hub_reset),
    .push_i    (capture),
    .pop_i     (pop),
    .din_i     (fifo_din),
    .dout_o    (fifo_dout),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .push_ok_o (fifo_push_ok),
    .count_o   (rec_count)
  );

  // push_ok mirrors ~drop for captures; it is kept for visibility in waves.
  logic unused_push_ok;
  assign unused_push_ok = fifo_push_ok;

  assign rec_valid  = ~fifo_empty;
  assign rec_data   = fifo_dout[RW-1:TS_WIDTH];
  assign rec_time   = fifo_dout[TS_WIDTH-1:0];
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dut_output_monitor.sv
module tb_dut_output_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       clr;
  logic       rdy;
  logic [7:0] dout;

  // Instance 0: ON_CHANGE=1, 32-bit timestamps
  logic        v0, o0;
  logic [7:0]  d0;
  logic [31:0] t0;
  logic [4:0]  c0;
  logic [15:0] dc0;
  // Instance 1: ON_CHANGE=0, 4-bit timestamps (wraps quickly)
  logic        v1, o1;
  logic [7:0]  d1;
  logic [3:0]  t1;
  logic [4:0]  c1;
  logic [15:0] dc1;

  dut_output_monitor u_dut0 (
    .hub_clocks     (clk),
    .hub_reset      (rst),
    .enable         (en),
    .dut_outputs    (dout),
    .rec_valid      (v0),
    .rec_ready      (rdy),
    .rec_data       (d0),
    .rec_time       (t0),
    .rec_count      (c0),
    .overflow       (o0),
    .drop_count     (dc0),
    .clear_overflow (clr)
  );

  dut_output_monitor #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .TS_WIDTH   (4),
    .ON_CHANGE  (1'b0)
  ) u_dut1 (
    .hub_clocks     (clk),
    .hub_reset      (rst),
    .enable         (en),
    .dut_outputs    (dout),
    .rec_valid      (v1),
    .rec_ready      (rdy),
    .rec_data       (d1),
    .rec_time       (t1),
    .rec_count      (c1),
    .overflow       (o1),
    .drop_count     (dc1),
    .clear_overflow (clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: a list of records per instance --------
  int               oc [2] = '{1, 0};
  int               tw [2] = '{32, 4};
  logic [7:0]       md   [2][16];
  longint unsigned  mt   [2][16];
  int               mn   [2];
  longint unsigned  mcnt [2];
  logic [7:0]       mlast[2];
  bit               mfp  [2];
  bit               movf [2];
  int               mdc  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mcnt[i] = 0; mlast[i] = 8'h00;
      mfp[i] = 1'b1; movf[i] = 1'b0; mdc[i] = 0;
    end
  endtask

  task automatic model_step(input bit e, input logic [7:0] x, input bit r, input bit c);
    for (int i = 0; i < 2; i++) begin
      bit pop, cap, full, drop;
      pop  = (mn[i] > 0) && r;
      full = (mn[i] == 16);
      cap  = e && (oc[i] == 0 || mfp[i] || x != mlast[i]);
      drop = cap && full && !pop;
      if (pop) begin
        for (int k = 0; k < 15; k++) begin
          md[i][k] = md[i][k+1];
          mt[i][k] = mt[i][k+1];
        end
        mn[i]--;
      end
      if (cap && !drop) begin
        md[i][mn[i]] = x;
        mt[i][mn[i]] = mcnt[i];
        mn[i]++;
      end
      if (drop) begin
        movf[i] = 1'b1;
        mdc[i]  = c ? 1 : ((mdc[i] == 65535) ? 65535 : mdc[i] + 1);
      end else if (c) begin
        movf[i] = 1'b0;
        mdc[i]  = 0;
      end
      if (cap) begin
        mlast[i] = x;
        mfp[i]   = 1'b0;
      end
      if (!e) mfp[i] = 1'b1;
      if (e)  mcnt[i] = (mcnt[i] + 1) % (64'd1 << tw[i]);
    end
  endtask

  task automatic check_inst(input int i, input logic v, input logic [7:0] d, input logic [31:0] t,
                            input logic [4:0] c, input logic o, input logic [15:0] dc);
    string p;
    p = (i == 0) ? "u0" : "u1";
    check({p, "_valid"}, longint'(v), longint'(mn[i] > 0));
    if (mn[i] > 0) begin
      check({p, "_data"}, longint'(d), longint'(md[i][0]));
      check({p, "_time"}, longint'(t), mt[i][0]);
    end
    check({p, "_count"}, longint'(c), longint'(mn[i]));
    check({p, "_ovf"}, longint'(o), longint'(movf[i]));
    check({p, "_drops"}, longint'(dc), longint'(mdc[i]));
  endtask

  task automatic check_all();
    check_inst(0, v0, d0, t0, c0, o0, dc0);
    check_inst(1, v1, d1, {28'h0, t1}, c1, o1, dc1);
  endtask

  // Called at a negedge: check current outputs, drive inputs for the next edge.
  task automatic cycle(input bit e, input logic [7:0] x, input bit r, input bit c);
    check_all();
    en = e; dout = x; rdy = r; clr = c;
    model_step(e, x, r, c);
    @(negedge clk);
  endtask

  // Reset asserted a few ns after a rising edge; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_u0_valid", longint'(v0), 0);
    check("rst_u0_count", longint'(c0), 0);
    check("rst_u0_data", longint'(d0), 0);
    check("rst_u0_time", longint'(t0), 0);
    check("rst_u0_ovf", longint'(o0), 0);
    check("rst_u0_drops", longint'(dc0), 0);
    check("rst_u1_valid", longint'(v1), 0);
    check("rst_u1_count", longint'(c1), 0);
    model_reset();
    en = 1'b0; clr = 1'b0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0; dout = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // After release, nothing appears while disabled
    repeat (3) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);

    // Change-only capture: 00,00,05,05,07
    do_reset();
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    check("chg_count", longint'(c0), 3);
    check("chg_head_data", longint'(d0), 0);
    check("chg_head_time", longint'(t0), 0);
    repeat (4) cycle(1'b0, 8'h07, 1'b1, 1'b0);

    // Overflow: 20 enabled cycles with no consumer, timestamps wrap on u1
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("ovf_count", longint'(c1), 16);
    check("ovf_flag", longint'(o1), 1);
    check("ovf_drops", longint'(dc1), 4);
    check("ovf_head_time", longint'(t1), 0);

    // Clear on the same edge as a drop: drop wins
    cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    check("clrdrop_flag", longint'(o1), 1);
    check("clrdrop_drops", longint'(dc1), 1);

    // Full with same-edge pop and capture: accepted, head advances
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    check("fullpop_count", longint'(c1), 16);
    check("fullpop_drops", longint'(dc1), 1);
    check("fullpop_head_time", longint'(t1), 1);

    // Clear, drain, then toggling backpressure over 10 captures
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (18) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) cycle(k < 10, 8'(k + 1), k[0], 1'b0);

    // Randomized traffic with varying consumer pressure and a mid-run reset
    for (int seg = 0; seg < 4; seg++) begin
      if (seg == 2) do_reset();
      for (int k = 0; k < 300; k++) begin
        bit e, r, c;
        e = ($urandom_range(0, 7) != 0);
        r = ($urandom_range(0, 9) < (seg * 3 + 2));
        c = ($urandom_range(0, 31) == 0);
        cycle(e, 8'($urandom_range(0, 3)), r, c);
      end
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
